// File: rtl/lsu_load_align_if.sv
// Load-aligner bundle: core request, memory request/response and result channels.
// The slave modport is the aligner itself; master is the core/memory side driving it.
interface lsu_load_align_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct;
    logic [XLEN-1:0] req_addr;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;

    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_fault;

    logic            busy;

    modport master (
        output req_valid, req_funct, req_addr, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, rsp_ready,
        input  req_ready, mem_req_valid, mem_req_addr,
               rsp_valid, rsp_data, rsp_fault, busy
    );

    modport slave (
        input  req_valid, req_funct, req_addr, mem_req_ready,
               mem_rsp_valid, mem_rsp_data, rsp_ready,
        output req_ready, mem_req_valid, mem_req_addr,
               rsp_valid, rsp_data, rsp_fault, busy
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load aligner: fetches one or two memory words, extracts the addressed bytes and extends them.
// Define LSU_MISALIGN_EN to split word-crossing loads into two beats; otherwise they fault.
module lsu_load_align #(
    parameter int XLEN   = 32,
    parameter int NBYTES = XLEN / 8
) (
    input logic             clk,
    input logic             rst,
    lsu_load_align_if.slave bus
);
    localparam int OFFW = $clog2(NBYTES);

`ifdef LSU_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      funct_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] word0_q;
    logic            rsp_valid_q;
    logic            rsp_fault_q;
    logic [XLEN-1:0] rsp_data_q;

    logic            accept;
    logic [OFFW-1:0] req_off;
    logic [OFFW-1:0] off_q;
    logic [XLEN-1:0] aligned_addr;
    logic            idle_fault;
    logic [XLEN-1:0] low;
    logic [XLEN-1:0] load_data;
    logic            fill;

    function automatic logic funct_legal(input logic [2:0] f);
        case (f)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct_legal = 1'b1;
            3'b011, 3'b110:                         funct_legal = (XLEN == 64);
            default:                                funct_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] size_of(input logic [1:0] f);
        size_of = 5'd1 << f;
    endfunction

    function automatic logic crosses(input logic [2:0] f, input logic [OFFW-1:0] off);
        crosses = (5'(off) + size_of(f[1:0])) > 5'(NBYTES);
    endfunction

    assign accept       = bus.req_valid && bus.req_ready;
    assign req_off      = bus.req_addr[OFFW-1:0];
    assign off_q        = addr_q[OFFW-1:0];
    assign aligned_addr = {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign idle_fault   = !funct_legal(bus.req_funct) ||
                          (crosses(bus.req_funct, req_off) && !MISALIGN_EN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)            state_next = idle_fault ? RESP : REQ0;
            REQ0:    if (bus.mem_req_ready) state_next = WAIT0;
            WAIT0:   if (bus.mem_rsp_valid) state_next = crosses(funct_q, off_q) ? REQ1 : RESP;
            REQ1:    if (bus.mem_req_ready) state_next = WAIT1;
            WAIT1:   if (bus.mem_rsp_valid) state_next = RESP;
            RESP:    if (bus.rsp_ready)     state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready     = (state == IDLE) && !rst;
        bus.mem_req_valid = (state == REQ0) || (state == REQ1);
        bus.mem_req_addr  = (state == REQ1) ? aligned_addr + XLEN'(NBYTES) : aligned_addr;
        bus.busy          = (state != IDLE);
    end

    // The second beat arrives live on mem_rsp_data, so {word1,word0} is formed from the bus.
    always_comb begin
        low = (state == WAIT1) ? XLEN'({bus.mem_rsp_data, word0_q} >> {off_q, 3'b000})
                               : XLEN'({{XLEN{1'b0}}, bus.mem_rsp_data} >> {off_q, 3'b000});
        case (funct_q[1:0])
            2'b00:   fill = low[7];
            2'b01:   fill = low[15];
            2'b10:   fill = low[31];
            default: fill = low[XLEN-1];
        endcase
        fill      = fill & ~funct_q[2];
        load_data = low;
        for (int i = 0; i < NBYTES; i++) begin
            load_data[i*8 +: 8] = (i < int'(size_of(funct_q[1:0]))) ? low[i*8 +: 8] : {8{fill}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct_q     <= '0;
            addr_q      <= '0;
            word0_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (accept) begin
                funct_q <= bus.req_funct;
                addr_q  <= bus.req_addr;
            end
            if (state == WAIT0 && bus.mem_rsp_valid) word0_q <= bus.mem_rsp_data;
            if (state != RESP && state_next == RESP) begin
                rsp_valid_q <= 1'b1;
                rsp_fault_q <= (state == IDLE);
                rsp_data_q  <= (state == IDLE) ? '0 : load_data;
            end else if (state == RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
                rsp_fault_q <= 1'b0;
                rsp_data_q  <= '0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_lsu_load_align.sv
// Directed bench for lsu_load_align at XLEN=32; expectations follow LSU_MISALIGN_EN if defined.
module tb_lsu_load_align;
    localparam int XLEN = 32;

`ifdef LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    lsu_load_align_if #(.XLEN(XLEN)) bus ();

    lsu_load_align #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  funct;
        logic [31:0] addr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_data;
        logic        exp_fault;
        int          exp_nreq;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
        int          exp_cycles;
        int          hold;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[16];

    function automatic vec_t mk(input logic [2:0] funct, input logic [31:0] addr,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] data, input logic fault, input int nreq,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input int cycles, input int hold);
        vec_t v;
        v.funct = funct; v.addr = addr; v.w0 = w0; v.w1 = w1;
        v.exp_data = data; v.exp_fault = fault; v.exp_nreq = nreq;
        v.exp_a0 = a0; v.exp_a1 = a1; v.exp_cycles = cycles; v.hold = hold;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one load, playing a one-cycle-latency memory, then checks result, beats and timing.
    task automatic applyStimulus(input vec_t v, input string tag);
        logic [31:0] a0, a1, due_addr;
        int          nreq, cycles;
        bit          due;
        @(negedge clk);
        checkOutput($sformatf("%s req_ready_idle", tag), 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_funct = v.funct;
        bus.req_addr  = v.addr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        nreq = 0; cycles = 0; due = 1'b0; a0 = '0; a1 = '0; due_addr = '0;
        while (!bus.rsp_valid && cycles < 50) begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_req_ready = 1'b0;
            if (due) begin
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rsp_data  = (due_addr == {v.addr[31:2], 2'b00}) ? v.w0 : v.w1;
                due = 1'b0;
            end else if (bus.mem_req_valid) begin
                if (nreq == 0) a0 = bus.mem_req_addr;
                else           a1 = bus.mem_req_addr;
                nreq++;
                bus.mem_req_ready = 1'b1;
                due_addr = bus.mem_req_addr;
                due = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        checkOutput($sformatf("%s rsp_valid", tag), 32'(bus.rsp_valid), 32'd1);
        checkOutput($sformatf("%s rsp_data", tag), bus.rsp_data, v.exp_data);
        checkOutput($sformatf("%s rsp_fault", tag), 32'(bus.rsp_fault), 32'(v.exp_fault));
        checkOutput($sformatf("%s mem_reqs", tag), 32'(nreq), 32'(v.exp_nreq));
        checkOutput($sformatf("%s latency", tag), 32'(cycles), 32'(v.exp_cycles));
        if (v.exp_nreq >= 1) checkOutput($sformatf("%s addr0", tag), a0, v.exp_a0);
        if (v.exp_nreq >= 2) checkOutput($sformatf("%s addr1", tag), a1, v.exp_a1);
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s hold%0d valid", tag, k), 32'(bus.rsp_valid), 32'd1);
            checkOutput($sformatf("%s hold%0d data", tag, k), bus.rsp_data, v.exp_data);
            checkOutput($sformatf("%s hold%0d req_ready", tag, k), 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checkOutput($sformatf("%s rsp_valid_drop", tag), 32'(bus.rsp_valid), 32'd0);
        checkOutput($sformatf("%s req_ready_after", tag), 32'(bus.req_ready), 32'd1);
        checkOutput($sformatf("%s busy_after", tag), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = mk(3'b000, 32'h1003, 32'h80FF1234, 32'h0, 32'hFFFFFF80, 1'b0, 1, 32'h1000, 32'h0, 2, 5);
        vecs[1]  = mk(3'b101, 32'h1002, 32'hABCD0000, 32'h0, 32'h0000ABCD, 1'b0, 1, 32'h1000, 32'h0, 2, 0);
        vecs[2]  = mk(3'b001, 32'h1001, 32'h00C3B200, 32'h0, 32'hFFFFC3B2, 1'b0, 1, 32'h1000, 32'h0, 2, 0);
        vecs[3]  = mk(3'b010, 32'h1000, 32'h12345678, 32'h0, 32'h12345678, 1'b0, 1, 32'h1000, 32'h0, 2, 0);
        vecs[4]  = mk(3'b100, 32'h2001, 32'h0000F000, 32'h0, 32'h000000F0, 1'b0, 1, 32'h2000, 32'h0, 2, 0);
        vecs[5]  = mk(3'b000, 32'h2000, 32'h0000007F, 32'h0, 32'h0000007F, 1'b0, 1, 32'h2000, 32'h0, 2, 0);
        vecs[6]  = mk(3'b001, 32'h2002, 32'h7FFF0000, 32'h0, 32'h00007FFF, 1'b0, 1, 32'h2000, 32'h0, 2, 0);
        vecs[7]  = mk(3'b100, 32'h1007, 32'hDEADBEEF, 32'h0, 32'h000000DE, 1'b0, 1, 32'h1004, 32'h0, 2, 0);
        vecs[8]  = mk(3'b011, 32'h1000, 32'h11111111, 32'h0, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, 0);
        vecs[9]  = mk(3'b110, 32'h1004, 32'h11111111, 32'h0, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, 0);
        vecs[10] = mk(3'b111, 32'h1000, 32'h11111111, 32'h0, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, 0);
        if (MIS) begin
            vecs[11] = mk(3'b010, 32'h1001, 32'h44332211, 32'h88776655, 32'h55443322, 1'b0, 2, 32'h1000, 32'h1004, 4, 0);
            vecs[12] = mk(3'b101, 32'h1003, 32'h44332211, 32'h88776655, 32'h00005544, 1'b0, 2, 32'h1000, 32'h1004, 4, 0);
            vecs[13] = mk(3'b001, 32'h1003, 32'h80000000, 32'h000000FF, 32'hFFFFFF80, 1'b0, 2, 32'h1000, 32'h1004, 4, 0);
            vecs[14] = mk(3'b010, 32'h1002, 32'h44332211, 32'h88776655, 32'h66554433, 1'b0, 2, 32'h1000, 32'h1004, 4, 2);
        end else begin
            vecs[11] = mk(3'b010, 32'h1001, 32'h44332211, 32'h88776655, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, 0);
            vecs[12] = mk(3'b101, 32'h1003, 32'h44332211, 32'h88776655, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, 0);
            vecs[13] = mk(3'b001, 32'h1003, 32'h80000000, 32'h000000FF, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, 0);
            vecs[14] = mk(3'b010, 32'h1002, 32'h44332211, 32'h88776655, 32'h0, 1'b1, 0, 32'h0, 32'h0, 0, 2);
        end
        vecs[15] = mk(3'b010, 32'h3000, 32'h0BADBEEF, 32'h0, 32'h0BADBEEF, 1'b0, 1, 32'h3000, 32'h0, 2, 0);

        bus.req_valid     = 1'b0;
        bus.req_funct     = 3'b000;
        bus.req_addr      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.rsp_ready     = 1'b0;
        rst = 1'b1;
        #12;
        checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset rsp_fault", 32'(bus.rsp_fault), 32'd0);
        checkOutput("reset rsp_data", bus.rsp_data, 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

        // Reset lands while the aligner waits for word0; the stale response must be dropped.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_funct = 3'b010;
        bus.req_addr  = 32'h3000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checkOutput("abort mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        checkOutput("abort busy_wait0", 32'(bus.busy), 32'd1);
        checkOutput("abort mem_req_idle_wait0", 32'(bus.mem_req_valid), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("abort busy_rst", 32'(bus.busy), 32'd0);
        checkOutput("abort req_ready_rst", 32'(bus.req_ready), 32'd0);
        checkOutput("abort rsp_valid_rst", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hCAFEF00D;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("abort late%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd0);
            checkOutput($sformatf("abort late%0d busy", k), 32'(bus.busy), 32'd0);
            checkOutput($sformatf("abort late%0d req_ready", k), 32'(bus.req_ready), 32'd1);
            @(negedge clk);
        end
        applyStimulus(vecs[15], "post_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
